// File: rtl/dot_loader.sv
// dot_loader: feeds host A/B element pairs into a dot-product engine, waits a fixed
// engine latency, then returns the engine result. Optional: DOT_LOADER_LAST_CHECK_EN.
module dot_loader #(
  parameter int VEC_LEN     = 10,
  parameter int WAIT_CYCLES = 820
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [3:0]  eng_cmd,
  output logic [15:0] eng_a,
  output logic [15:0] eng_b,
  input  logic [15:0] eng_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(VEC_LEN - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [3:0] CMD_IDLE  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_CLEAR = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_PAD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [WW-1:0] wcnt_reg, wcnt_next;
  logic [3:0]    cmd_reg, cmd_next;
  logic [15:0]   eng_a_reg, a_next;
  logic [15:0]   eng_b_reg, b_next;
  logic [15:0]   res_data_reg, res_next;
  logic          accept;

`ifdef DOT_LOADER_LAST_CHECK_EN
  logic err_reg, err_next;
  assign err = err_reg;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err = 1'b0;
`endif

  assign in_ready  = (state_reg == S_LOAD);
  assign accept    = in_valid && in_ready;
  assign res_valid = (state_reg == S_OUT);
  assign busy      = (state_reg != S_IDLE);
  assign eng_cmd   = cmd_reg;
  assign eng_a     = eng_a_reg;
  assign eng_b     = eng_b_reg;
  assign res_data  = res_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      wcnt_reg     <= '0;
      cmd_reg      <= CMD_IDLE;
      eng_a_reg    <= '0;
      eng_b_reg    <= '0;
      res_data_reg <= '0;
`ifdef DOT_LOADER_LAST_CHECK_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wcnt_reg     <= wcnt_next;
      cmd_reg      <= cmd_next;
      eng_a_reg    <= a_next;
      eng_b_reg    <= b_next;
      res_data_reg <= res_next;
`ifdef DOT_LOADER_LAST_CHECK_EN
      err_reg      <= err_next;
`endif
    end
  end

  // Engine command is registered: whatever is decided here appears on eng_cmd next cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wcnt_next  = wcnt_reg;
    cmd_next   = CMD_IDLE;
    a_next     = eng_a_reg;
    b_next     = eng_b_reg;
    res_next   = res_data_reg;
`ifdef DOT_LOADER_LAST_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        cnt_next  = '0;
        wcnt_next = '0;
        if (in_valid) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        cmd_next   = CMD_CLEAR;
        cnt_next   = '0;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          cmd_next = CMD_WRITE;
          a_next   = in_a;
          b_next   = in_b;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next = S_WAIT;
`ifdef DOT_LOADER_LAST_CHECK_EN
            if (!in_last) err_next = 1'b1;
`endif
          end
`ifdef DOT_LOADER_LAST_CHECK_EN
          else if (in_last) begin
            err_next   = 1'b1;
            state_next = S_PAD;
          end
`endif
        end
      end
      // Early in_last: fill the rest of the vector with zero products.
      S_PAD: begin
        cmd_next = CMD_WRITE;
        a_next   = '0;
        b_next   = '0;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_reg == WAIT_LAST) begin
          res_next   = eng_result;
          wcnt_next  = '0;
          state_next = S_OUT;
        end else begin
          wcnt_next = wcnt_reg + WW'(1);
        end
      end
      S_OUT: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dot_loader.sv
// Scoreboard bench for dot_loader: random vectors, behavioural engine, decoupled monitor.
module tb_dot_loader;
  localparam int VEC_LEN     = 10;
  localparam int WAIT_CYCLES = 820;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [3:0]  eng_cmd;
  logic [15:0] eng_a;
  logic [15:0] eng_b;
  logic [15:0] eng_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  dot_loader #(.VEC_LEN(VEC_LEN), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .eng_cmd(eng_cmd),
    .eng_a(eng_a), .eng_b(eng_b), .eng_result(eng_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  bit exp_err = 1'b0;
  int hold_cnt = 0;
  bit force_ready = 1'b0;
  logic [31:0] wr_q[$];
  logic [15:0] res_q[$];
  logic signed [15:0] va[VEC_LEN];
  logic signed [15:0] vb[VEC_LEN];

  // Behavioural engine: clear on 2, accumulate a*b on 1; result scrambled while OUT.
  int acc = 0;
  logic [15:0] noise = 16'h0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 16'($urandom);
    if (eng_cmd == 4'd2) acc <= 0;
    else if (eng_cmd == 4'd1) acc <= acc + int'($signed(eng_a)) * int'($signed(eng_b));
  end
  assign eng_result = acc[15:0] ^ (res_valid ? noise : 16'h0);

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // Consumer of results.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (res_valid && hold_cnt > 0) begin
        res_ready = 1'b0;
        hold_cnt--;
      end else if (force_ready) res_ready = 1'b1;
      else res_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor.
  bit seen_clear = 1'b0;
  int wsc = 0;
  bit prev_valid = 1'b0, prev_ready = 1'b0, idle_chk = 1'b0;
  logic [15:0] prev_data = 16'h0;
  always @(negedge clk) begin
    if (reset) begin
      seen_clear = 1'b0;
      wsc = 0;
      prev_valid = 1'b0;
      idle_chk = 1'b0;
    end else begin
      check("err", 64'(err), 64'(exp_err));
      if (idle_chk) begin
        check("return_idle", {62'h0, res_valid, busy}, 64'h0);
        idle_chk = 1'b0;
      end
      if (eng_cmd == 4'd2) begin
        check("clear_position", 64'(wsc == 0 || wsc == VEC_LEN), 64'h1);
        seen_clear = 1'b1;
        wsc = 0;
      end else if (eng_cmd == 4'd1) begin
        check("write_framed", 64'(seen_clear && wsc < VEC_LEN), 64'h1);
        wsc++;
        if (wr_q.size() == 0) check("write_expected", 64'h0, 64'h1);
        else check("eng_ab", {32'h0, eng_a, eng_b}, 64'(wr_q.pop_front()));
      end else begin
        check("cmd_idle", 64'(eng_cmd), 64'h0);
      end
      if (wsc == VEC_LEN) check("ready_after_full", 64'(in_ready), 64'h0);
      if (res_valid && !prev_valid) check("latency", 64'(cyc - last_acc), 64'(WAIT_CYCLES + 1));
      if (res_valid && prev_valid && !prev_ready) check("res_hold", 64'(res_data), 64'(prev_data));
      if (res_valid && res_ready) begin
        check("frame_done", 64'(wsc), 64'(VEC_LEN));
        if (res_q.size() == 0) check("res_expected", 64'h0, 64'h1);
        else check("res_data", 64'(res_data), 64'(res_q.pop_front()));
        idle_chk = 1'b1;
      end
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = res_data;
    end
  end

  task automatic wait_accept(output bit ok, output int c);
    ok = 1'b0;
    c = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        c = cyc;
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    check("reset_outputs", {8'h0, in_ready, eng_cmd, eng_a, eng_b, res_valid, res_data, err, busy}, 64'h0);
    wr_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_result();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (res_q.size() == 0) return;
    end
    check("result_timeout", 64'h0, 64'h1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < VEC_LEN; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
  endtask

  // Host driver: expected engine writes and expected result enter the scoreboard per accept.
  task automatic send_vector(input int nel, input bit gap, input int abort_at, input bit last_ok);
    int ex;
    int c;
    bit ok;
    ex = 0;
    for (int i = 0; i < nel; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
`ifdef DOT_LOADER_LAST_CHECK_EN
      in_last = last_ok && (i == nel - 1);
`else
      in_last = last_ok ? 1'($urandom) : 1'b0;
`endif
      wait_accept(ok, c);
      if (!ok) return;
      wr_q.push_back({va[i], vb[i]});
      ex += int'(va[i]) * int'(vb[i]);
`ifdef DOT_LOADER_LAST_CHECK_EN
      if ((in_last && i < VEC_LEN - 1) || (!in_last && i == VEC_LEN - 1)) exp_err = 1'b1;
`endif
      if (abort_at == i + 1) begin
        in_valid = 1'b0;
        reset_pulse();
        return;
      end
      if (i == nel - 1) begin
        for (int p = nel; p < VEC_LEN; p++) wr_q.push_back(32'h0);
        last_acc = c + VEC_LEN - nel;
        res_q.push_back(ex[15:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = 16'h0;
    in_b = 16'h0;
    in_last = 1'b0;
    #2;
    check("reset_state", {8'h0, in_ready, eng_cmd, eng_a, eng_b, res_valid, res_data, err, busy}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // A=1..10, B=1, consumer always ready: sum 55.
    for (int i = 0; i < VEC_LEN; i++) begin
      va[i] = 16'(i + 1);
      vb[i] = 16'sd1;
    end
    force_ready = 1'b1;
    send_vector(VEC_LEN, 1'b0, 0, 1'b1);
    wait_result();
    force_ready = 1'b0;

    // Alternate-cycle in_valid.
    fill_random();
    send_vector(VEC_LEN, 1'b1, 0, 1'b1);
    wait_result();

    // Consumer stalls 50 cycles in OUT while eng_result churns.
    hold_cnt = 50;
    fill_random();
    send_vector(VEC_LEN, 1'b0, 0, 1'b1);
    wait_result();

    // Reset after the 4th accept, then a fresh vector.
    fill_random();
    send_vector(VEC_LEN, 1'b0, 4, 1'b1);
    fill_random();
    send_vector(VEC_LEN, 1'b0, 0, 1'b1);
    wait_result();

    for (int r = 0; r < 4; r++) begin
      fill_random();
      send_vector(VEC_LEN, 1'($urandom), 0, 1'b1);
      wait_result();
    end

`ifdef DOT_LOADER_LAST_CHECK_EN
    // Missing in_last on the final element.
    fill_random();
    send_vector(VEC_LEN, 1'b0, 0, 1'b0);
    wait_result();
    reset_pulse();
    // in_last on the 3rd element: seven zero-padded writes follow.
    fill_random();
    send_vector(3, 1'b0, 0, 1'b1);
    wait_result();
`endif

    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("wr_q_drained", 64'(wr_q.size()), 64'h0);
    check("res_q_drained", 64'(res_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_loader.md
DOT_LOADER -- requirements
Module: dot_loader

Interface
REQ-001 SHALL expose parameter VEC_LEN, default 10: elements written per vector to the dot-product engine.
REQ-002 SHALL expose parameter WAIT_CYCLES, default 820: cycles held in WAIT before sampling the engine result.
REQ-003 SHALL expose ports as follows; one clock; reset is asynchronous and active-high:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  host element valid
- in_ready  out  1  host element accepted when in_valid&&in_ready
- in_a  in  16  host A element, signed
- in_b  in  16  host B element, signed
- in_last  in  1  host marks final element of vector
- eng_cmd  out  4  engine command: 0 idle, 1 write, 2 clear
- eng_a  out  16  engine A data
- eng_b  out  16  engine B data
- eng_result  in  16  engine accumulated result
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  16  captured result
- busy  out  1  high in any state except IDLE
- err  out  1  sticky framing error

Function
REQ-004 SHALL implement the FSM IDLE -> CLEAR -> LOAD -> WAIT -> OUT -> IDLE.
REQ-005 In IDLE, in_ready SHALL be 0, and in_valid=1 SHALL move the FSM to CLEAR on the next edge.
REQ-006 CLEAR SHALL last exactly one cycle, SHALL register eng_cmd=2 (visible the following cycle), and SHALL clear the element counter.
REQ-007 In LOAD, in_ready SHALL be 1, and each accept SHALL register eng_cmd=1, eng_a=in_a, eng_b=in_b for exactly one cycle, so one engine write occurs per accept.
REQ-008 Cycles in LOAD without an accept SHALL register eng_cmd=0, leaving eng_a/eng_b unchanged.
REQ-009 The element counter SHALL be ceil(log2(VEC_LEN+1)) bits wide and SHALL increment per accept; the accept that brings the count to VEC_LEN SHALL move the FSM to WAIT, with in_ready=0 from that next cycle.
REQ-010 In WAIT, eng_cmd SHALL be 0, and a wait counter SHALL count WAIT_CYCLES cycles from the first WAIT cycle.
REQ-011 At WAIT_CYCLES, res_data SHALL latch eng_result and the FSM SHALL enter OUT.
REQ-012 In OUT, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready=1; that handshake SHALL return the FSM to IDLE, with res_valid=0 the next cycle.
REQ-013 In OUT with res_ready held 1, the handshake SHALL complete in one cycle; res_ready SHALL be ignored outside OUT.
REQ-014 The latency from the last accept to res_valid SHALL be WAIT_CYCLES+1 cycles.
REQ-015 in_valid arriving in WAIT or OUT SHALL NOT be accepted; the element SHALL remain pending at the host.
REQ-016 The block SHALL NOT alter data: eng_a/eng_b SHALL be bit-exact copies of in_a/in_b, and res_data SHALL be a bit-exact copy of eng_result.

Reset
REQ-017 Asserting reset SHALL immediately force state IDLE, zero both counters, and set eng_cmd=0, eng_a=0, eng_b=0, res_valid=0, res_data=0, err=0, busy=0, in_ready=0.
REQ-018 Reset mid-LOAD or mid-WAIT SHALL abandon the vector, and the first command after release SHALL be eng_cmd=2 once a new in_valid arrives.

Configuration
REQ-019 With DOT_LOADER_LAST_CHECK_EN defined, in_last=1 on an accept before count VEC_LEN SHALL set err, and the block SHALL zero-pad the remaining elements (eng_cmd=1, eng_a=eng_b=0, one per cycle, in_ready=0) before entering WAIT.
REQ-020 With DOT_LOADER_LAST_CHECK_EN defined, in_last=0 on the VEC_LEN-th accept SHALL set err, and the block SHALL proceed normally.
REQ-021 err SHALL remain set until reset.
REQ-022 Without DOT_LOADER_LAST_CHECK_EN, in_last SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-023 Reset, then 10 back-to-back accepts with A=1..10, B=1 -> one eng_cmd=2 cycle, then 10 consecutive eng_cmd=1 cycles carrying A=1..10, then res_valid exactly 821 cycles after the last accept with res_data=eng_result (model returns 55).
REQ-024 in_valid toggled every other cycle during LOAD -> exactly 10 eng_cmd=1 pulses separated by eng_cmd=0 cycles, and the count holds between accepts.
REQ-025 res_ready held 0 for 50 cycles in OUT, eng_result changed meanwhile -> res_data stays constant, res_valid stays 1, and the block returns to IDLE one cycle after res_ready=1.
REQ-026 reset pulsed after the 4th accept -> all outputs 0 immediately, and the next vector begins with eng_cmd=2.
REQ-027 With DOT_LOADER_LAST_CHECK_EN defined, in_last on the 3rd accept -> err=1, 7 zero-padded writes with in_ready=0, then normal WAIT/OUT.
REQ-028 in_valid=1 throughout WAIT -> in_ready stays 0, and no eng_cmd other than 0 is issued.
